// File: rtl/lrrr_pkg.sv
// Shared types and default constants for the Lrrr behaviour controller.
// The optional random dive interval (macro LRRR_RANDOM_DIVE_EN) uses the LFSR constants below.
package lrrr_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENTRY  = 3'd1,
        ACTIVE = 3'd2,
        HIT    = 3'd3,
        DEAD   = 3'd4
    } lrrr_state_t;

    localparam int LIVES_DEF        = 5;
    localparam int ENTRY_FRAMES_DEF = 60;
    localparam int HIT_FRAMES_DEF   = 30;
    localparam int DIVE_PERIOD_DEF  = 90;
    localparam int Y_LIMIT_DEF      = 300;
    localparam int Y_HYST_DEF       = 16;
    localparam int BLINK_DIV_DEF    = 4;

    // Taps 8,6,5,4 map to bit indices 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic lfsr_fb(input logic [7:0] q);
        return ^(q & LFSR_TAPS);
    endfunction

    // Visible/blank phase: blanked while (cnt / div) is even.
    function automatic logic blink_on(input logic [7:0] cnt, input logic [7:0] div);
        logic [7:0] phase;
        phase = cnt / div;
        return ~phase[0];
    endfunction

endpackage

// File: rtl/lrrr_lfsr.sv
// 8-bit Fibonacci LFSR advancing once per enable pulse; only used when
// LRRR_RANDOM_DIVE_EN is defined.
module lrrr_lfsr
    import lrrr_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [7:0] q
);

    // Shift register: reseeded on reset, steps on each enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= {q[6:0], lfsr_fb(q)};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/lrrr_ctrl.sv
// Lrrr boss behaviour controller: lifecycle FSM, lives, blink and Y-reversal pulses.
// Define LRRR_RANDOM_DIVE_EN for an LFSR-randomised dive interval.
module lrrr_ctrl
    import lrrr_pkg::*;
#(
    parameter int LIVES        = LIVES_DEF,
    parameter int ENTRY_FRAMES = ENTRY_FRAMES_DEF,
    parameter int HIT_FRAMES   = HIT_FRAMES_DEF,
    parameter int DIVE_PERIOD  = DIVE_PERIOD_DEF,
    parameter int Y_LIMIT      = Y_LIMIT_DEF,
    parameter int Y_HYST       = Y_HYST_DEF,
    parameter int BLINK_DIV    = BLINK_DIV_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        startGame,
    input  logic        lrrrHit,
    input  logic [10:0] topLeftY,
    output logic        waiting,
    output logic        toggleY,
    output logic [2:0]  lrrrLives,
    output logic        lrrrBlank,
    output logic        lrrrDead
);

    localparam logic [2:0]  LIVES_L    = 3'(LIVES);
    localparam logic [7:0]  ENTRY_LAST = 8'(ENTRY_FRAMES - 1);
    localparam logic [7:0]  HIT_LAST   = 8'(HIT_FRAMES - 1);
    localparam logic [7:0]  DIVE_LAST  = 8'(DIVE_PERIOD - 1);
    localparam logic [7:0]  BLINK_L    = 8'(BLINK_DIV);
    localparam logic [10:0] Y_LIM      = 11'(Y_LIMIT);
    localparam logic [10:0] Y_REARM    = 11'(Y_LIMIT - Y_HYST);

    lrrr_state_t state_r, state_nx_s;
    logic [7:0]  frm_cnt_r, frm_inc_s, frm_nx_s;
    logic [7:0]  dive_cnt_r, dive_nx_s, dive_lim_s;
    logic        armed_r, armed_nx_s;
    logic [2:0]  lives_nx_s, lives_dec_s;
    logic        in_motion_s, dive_wrap_s, req_s;
    logic        wait_nx_s, toggle_nx_s, blank_nx_s;

    assign in_motion_s = (state_r == ACTIVE) || (state_r == HIT);
    assign dive_wrap_s = in_motion_s && startOfFrame && (dive_cnt_r == dive_lim_s);
    assign lives_dec_s = (lrrrLives == 3'd0) ? 3'd0 : lrrrLives - 3'd1;
    assign frm_inc_s   = startOfFrame ? frm_cnt_r + 8'd1 : frm_cnt_r;

`ifdef LRRR_RANDOM_DIVE_EN
    localparam int DIVE_HALF = DIVE_PERIOD / 2;

    logic [7:0] lfsr_q_s;
    logic [7:0] dive_lim_r;

    lrrr_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (startOfFrame),
        .q     (lfsr_q_s)
    );

    // Next dive limit is drawn from the LFSR at every dive.
    always_ff @(posedge clk) begin
        if (reset) begin
            dive_lim_r <= DIVE_LAST;
        end else if (dive_wrap_s) begin
            dive_lim_r <= 8'(DIVE_HALF + (int'(lfsr_q_s) % DIVE_HALF) - 1);
        end else begin
            dive_lim_r <= dive_lim_r;
        end
    end

    assign dive_lim_s = dive_lim_r;
`else
    assign dive_lim_s = DIVE_LAST;
`endif

    // Next-state, counter and toggle-request logic.
    always_comb begin
        state_nx_s = state_r;
        lives_nx_s = lrrrLives;
        dive_nx_s  = dive_cnt_r;
        armed_nx_s = armed_r;
        req_s      = 1'b0;

        case (state_r)
            IDLE, DEAD: begin
                if (startGame) begin
                    state_nx_s = ENTRY;
                    lives_nx_s = LIVES_L;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ENTRY: begin
                if (startOfFrame && (frm_cnt_r == ENTRY_LAST)) begin
                    state_nx_s = ACTIVE;
                    dive_nx_s  = 8'd0;
                end else begin
                    state_nx_s = ENTRY;
                end
            end
            ACTIVE: begin
                if (lrrrHit) begin
                    lives_nx_s = lives_dec_s;
                    if (lives_dec_s == 3'd0) begin
                        state_nx_s = DEAD;
                    end else begin
                        state_nx_s = HIT;
                        req_s      = 1'b1;
                    end
                end else begin
                    state_nx_s = ACTIVE;
                end
            end
            HIT: begin
                if (startOfFrame && (frm_cnt_r == HIT_LAST)) begin
                    state_nx_s = ACTIVE;
                end else begin
                    state_nx_s = HIT;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase

        if (dive_wrap_s) begin
            dive_nx_s = 8'd0;
            req_s     = 1'b1;
        end else if (in_motion_s && startOfFrame) begin
            dive_nx_s = dive_cnt_r + 8'd1;
        end else begin
            dive_nx_s = dive_nx_s;
        end

        // Guard fires once per crossing; hysteresis band prevents chatter at the limit.
        if (armed_r) begin
            if (in_motion_s && (topLeftY >= Y_LIM)) begin
                req_s      = 1'b1;
                armed_nx_s = 1'b0;
            end else begin
                armed_nx_s = 1'b1;
            end
        end else if (topLeftY < Y_REARM) begin
            armed_nx_s = 1'b1;
        end else begin
            armed_nx_s = 1'b0;
        end

        if (state_nx_s != state_r) begin
            frm_nx_s = 8'd0;
        end else begin
            frm_nx_s = frm_inc_s;
        end

        wait_nx_s   = !((state_nx_s == ACTIVE) || (state_nx_s == HIT));
        toggle_nx_s = req_s && !toggleY && !wait_nx_s;

        case (state_nx_s)
            DEAD:    blank_nx_s = 1'b1;
            HIT:     blank_nx_s = blink_on(frm_nx_s, BLINK_L);
            default: blank_nx_s = 1'b0;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            frm_cnt_r  <= 8'd0;
            dive_cnt_r <= 8'd0;
            armed_r    <= 1'b1;
            waiting    <= 1'b1;
            toggleY    <= 1'b0;
            lrrrLives  <= LIVES_L;
            lrrrBlank  <= 1'b0;
            lrrrDead   <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            frm_cnt_r  <= frm_nx_s;
            dive_cnt_r <= dive_nx_s;
            armed_r    <= armed_nx_s;
            waiting    <= wait_nx_s;
            toggleY    <= toggle_nx_s;
            lrrrLives  <= lives_nx_s;
            lrrrBlank  <= blank_nx_s;
            lrrrDead   <= (state_nx_s == DEAD);
        end
    end

endmodule

// File: tb/tb_lrrr_ctrl.sv
// Directed testbench for lrrr_ctrl with default parameters (random dive disabled).
module tb_lrrr_ctrl;

    logic        clk;
    logic        reset;
    logic        startOfFrame;
    logic        startGame;
    logic        lrrrHit;
    logic [10:0] topLeftY;
    logic        waiting;
    logic        toggleY;
    logic [2:0]  lrrrLives;
    logic        lrrrBlank;
    logic        lrrrDead;

    int n_asserts = 0;
    int n_fails   = 0;
    int tog_cnt;

    lrrr_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .startGame    (startGame),
        .lrrrHit      (lrrrHit),
        .topLeftY     (topLeftY),
        .waiting      (waiting),
        .toggleY      (toggleY),
        .lrrrLives    (lrrrLives),
        .lrrrBlank    (lrrrBlank),
        .lrrrDead     (lrrrDead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic start_game();
        startGame = 1'b1;
        tick();
        startGame = 1'b0;
    endtask

    task automatic hit_pulse();
        lrrrHit = 1'b1;
        tick();
        lrrrHit = 1'b0;
    endtask

    // Sweep topLeftY one step per clock and count toggle pulses seen.
    task automatic ramp(input int from, input int to, output int cnt);
        int step;
        cnt  = 0;
        step = (to >= from) ? 1 : -1;
        for (int v = from; v != to + step; v += step) begin
            topLeftY = 11'(v);
            tick();
            cnt += int'(toggleY);
        end
    endtask

    initial begin
        reset        = 1'b1;
        startOfFrame = 1'b0;
        startGame    = 1'b0;
        lrrrHit      = 1'b0;
        topLeftY     = 11'd100;
        tick();
        tick();
        check_val("rst_waiting", waiting, 1);
        check_val("rst_toggle", toggleY, 0);
        check_val("rst_lives", lrrrLives, 5);
        check_val("rst_blank", lrrrBlank, 0);
        check_val("rst_dead", lrrrDead, 0);
        reset = 1'b0;
        tick();

        // Entry delay and first dive
        start_game();
        check_val("entry_wait0", waiting, 1);
        repeat (59) frame();
        check_val("entry_wait59", waiting, 1);
        frame();
        check_val("entry_wait60", waiting, 0);
        check_val("entry_tog", toggleY, 0);
        tog_cnt = 0;
        repeat (89) begin
            frame();
            tog_cnt += int'(toggleY);
        end
        check_val("dive_early", tog_cnt, 0);
        frame();
        check_val("dive_pulse", toggleY, 1);
        tick();
        check_val("dive_low", toggleY, 0);

        // First hit: bounce, blink pattern, ignored hit during HIT
        hit_pulse();
        check_val("hit1_lives", lrrrLives, 4);
        check_val("hit1_tog", toggleY, 1);
        check_val("blank_k0", lrrrBlank, 1);
        for (int k = 1; k < 30; k++) begin
            frame();
            check_val($sformatf("blank_k%0d", k), lrrrBlank, ((k / 4) % 2 == 0) ? 1 : 0);
            if (k == 1) check_val("hit1_toglow", toggleY, 0);
            if (k == 10) begin
                hit_pulse();
                check_val("hitinhit_lives", lrrrLives, 4);
                check_val("hitinhit_tog", toggleY, 0);
            end
        end
        frame();
        check_val("hit1_end_blank", lrrrBlank, 0);
        check_val("hit1_end_wait", waiting, 0);

        // Second hit then reset in the middle of HIT
        hit_pulse();
        check_val("hit2_lives", lrrrLives, 3);
        check_val("hit2_tog", toggleY, 1);
        repeat (5) frame();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("midrst_waiting", waiting, 1);
        check_val("midrst_lives", lrrrLives, 5);
        check_val("midrst_tog", toggleY, 0);
        check_val("midrst_blank", lrrrBlank, 0);
        check_val("midrst_dead", lrrrDead, 0);

        // Floor guard with hysteresis
        start_game();
        repeat (60) frame();
        check_val("g_active", waiting, 0);
        ramp(280, 320, tog_cnt);
        check_val("guard_first", tog_cnt, 1);
        ramp(320, 284, tog_cnt);
        check_val("guard_down1", tog_cnt, 0);
        ramp(284, 320, tog_cnt);
        check_val("guard_norefire", tog_cnt, 0);
        ramp(320, 280, tog_cnt);
        check_val("guard_down2", tog_cnt, 0);
        ramp(280, 320, tog_cnt);
        check_val("guard_second", tog_cnt, 1);
        topLeftY = 11'd100;
        tick();

        // Five hits down to DEAD
        for (int i = 1; i <= 5; i++) begin
            tick();
            hit_pulse();
            check_val($sformatf("kill_lives%0d", i), lrrrLives, 5 - i);
            check_val($sformatf("kill_tog%0d", i), toggleY, (i < 5) ? 1 : 0);
            if (i < 5) begin
                repeat (30) frame();
                check_val($sformatf("kill_wait%0d", i), waiting, 0);
            end
        end
        check_val("dead_flag", lrrrDead, 1);
        check_val("dead_wait", waiting, 1);
        check_val("dead_blank", lrrrBlank, 1);
        hit_pulse();
        check_val("dead_sat", lrrrLives, 0);

        // Restart from DEAD, dive wrap coinciding with a hit
        start_game();
        check_val("restart_dead", lrrrDead, 0);
        check_val("restart_lives", lrrrLives, 5);
        check_val("restart_wait", waiting, 1);
        repeat (60) frame();
        repeat (89) frame();
        startOfFrame = 1'b1;
        lrrrHit      = 1'b1;
        tick();
        startOfFrame = 1'b0;
        lrrrHit      = 1'b0;
        check_val("coinc_tog", toggleY, 1);
        check_val("coinc_lives", lrrrLives, 4);
        topLeftY = 11'd310;
        tick();
        check_val("coinc_forcelow", toggleY, 0);
        topLeftY = 11'd100;
        tick();
        check_val("coinc_dropped", toggleY, 0);
        start_game();
        check_val("sg_ignored_lives", lrrrLives, 4);
        check_val("sg_ignored_wait", waiting, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
